i2c_cmd_queue: RTL and testbench

I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

---
 rtl/i2c_cmd_queue.sv | 148 ++++++++++++++
 tb/tb_i2c_cmd_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_queue.sv
// Command/response queue in front of a single-transaction I2C master: buffers commands, issues them one at a time, collects read data.
// Optional WAIT watchdog enabled by defining I2C_CMD_QUEUE_TIMEOUT_EN (sticky err_timeout after 1024 cycles without done_c).
module i2c_cmd_queue #(
  parameter int DEPTH         = 4,
  parameter int DATA_WIDTH    = 7,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw_bar,
  input  logic [ADDRESS_WIDTH:0] cmd_addr,
  input  logic [DATA_WIDTH:0]    cmd_wdata,
  output logic                   new_data,
  output logic                   rw_bar,
  output logic [ADDRESS_WIDTH:0] Addr,
  output logic [DATA_WIDTH:0]    Wdata,
  input  logic [DATA_WIDTH:0]    Rdata,
  input  logic                   done_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ADDRESS_WIDTH:0] rsp_addr,
  output logic [DATA_WIDTH:0]    rsp_rdata,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int AW    = ADDRESS_WIDTH + 1;
  localparam int DW    = DATA_WIDTH + 1;
  localparam int CMD_W = 1 + AW + DW;
  localparam int RSP_W = AW + DW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            r_state, w_next;
  logic [CMD_W-1:0]  r_cmd_mem [DEPTH];
  logic [RSP_W-1:0]  r_rsp_mem [DEPTH];
  logic [PTR_W-1:0]  r_cmd_wr, r_cmd_rd, r_rsp_wr, r_rsp_rd;
  logic              r_new_data, r_rw_bar;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic              w_cmd_full, w_cmd_empty, w_rsp_full, w_rsp_empty;
  logic              w_cmd_push, w_cmd_pop, w_rsp_push, w_rsp_pop;
  logic              w_timeout;
  logic [CMD_W-1:0]  w_cmd_head;
  logic [RSP_W-1:0]  w_rsp_head;

  assign w_cmd_full  = (r_cmd_wr[IDX_W] != r_cmd_rd[IDX_W]) &&
                       (r_cmd_wr[IDX_W-1:0] == r_cmd_rd[IDX_W-1:0]);
  assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
  assign w_rsp_full  = (r_rsp_wr[IDX_W] != r_rsp_rd[IDX_W]) &&
                       (r_rsp_wr[IDX_W-1:0] == r_rsp_rd[IDX_W-1:0]);
  assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);

  // Fullness is taken from registered pointers, so a pop at ISSUE cannot admit a push on the same edge.
  assign w_cmd_push = cmd_valid && !w_cmd_full;
  assign w_cmd_pop  = (r_state == S_ISSUE);
  assign w_rsp_push = (r_state == S_WAIT) && done_c && r_rw_bar;
  assign w_rsp_pop  = !w_rsp_empty && rsp_ready;

  assign w_cmd_head = r_cmd_mem[r_cmd_rd[IDX_W-1:0]];
  assign w_rsp_head = r_rsp_mem[r_rsp_rd[IDX_W-1:0]];

  // NOTE: storage arrays carry no reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wr[IDX_W-1:0]] <= {cmd_rw_bar, cmd_addr, cmd_wdata};
    if (w_rsp_push) r_rsp_mem[r_rsp_wr[IDX_W-1:0]] <= {r_addr, Rdata};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_wr <= '0;
      r_cmd_rd <= '0;
      r_rsp_wr <= '0;
      r_rsp_rd <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + PTR_W'(1);
      if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + PTR_W'(1);
      if (w_rsp_push) r_rsp_wr <= r_rsp_wr + PTR_W'(1);
      if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + PTR_W'(1);
    end
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_cmd_empty && !w_rsp_full) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (done_c || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The head is registered on the ISSUE edge together with the start strobe, so the
  // master sees new_data and a stable Addr/Wdata/rw_bar in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_new_data <= 1'b0;
      r_rw_bar   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_next;
      r_new_data <= (r_state == S_ISSUE);
      if (r_state == S_ISSUE) {r_rw_bar, r_addr, r_wdata} <= w_cmd_head;
    end
  end

`ifdef I2C_CMD_QUEUE_TIMEOUT_EN
  logic [9:0] r_wait_cnt;
  logic       r_err_timeout;

  // Counter value 1023 in a WAIT cycle means this is the 1024th cycle without done_c.
  assign w_timeout = (r_state == S_WAIT) && !done_c && (r_wait_cnt == 10'h3FF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 10'd1 : 10'd0;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready = !w_cmd_full;
  assign new_data  = r_new_data;
  assign rw_bar    = r_rw_bar;
  assign Addr      = r_addr;
  assign Wdata     = r_wdata;
  assign rsp_valid = !w_rsp_empty;
  assign rsp_addr  = w_rsp_head[RSP_W-1:DW];
  assign rsp_rdata = w_rsp_head[DW-1:0];
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: reset values, a vector table of single transactions,
// directed FIFO-full / response-full / reset-in-WAIT / timeout sequences, and a random run against a queue model.
module tb_i2c_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_rw_bar;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       new_data, rw_bar;
  logic [6:0] Addr;
  logic [7:0] Wdata, Rdata;
  logic       done_c;
  logic       rsp_valid, rsp_ready;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       busy, err_timeout;

  i2c_cmd_queue #(.DEPTH(DEPTH), .DATA_WIDTH(7), .ADDRESS_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw_bar(cmd_rw_bar),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .new_data(new_data), .rw_bar(rw_bar), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata), .done_c(done_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       exp_rsp;
    logic [6:0] exp_rsp_addr;
    logic [7:0] exp_rsp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 0; done_c = 0; rsp_ready = 0; Rdata = '0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
    bit ok = 0;
    cmd_rw_bar = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 0;
    check("push_accept", {31'd0, ok}, 1);
  endtask

  task automatic wait_nd(input string tag);
    bit seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      seen = new_data;
    end
    check(tag, {31'd0, seen}, 1);
  endtask

  task automatic complete(input logic [7:0] rd);
    done_c = 1; Rdata = rd;
    tick();
    done_c = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_new_data"}, new_data, 0);
    check({tag, "_rw_bar"}, rw_bar, 0);
    check({tag, "_addr"}, Addr, 0);
    check({tag, "_wdata"}, Wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    vec_t v;
    logic [14:0] exp_rsp [4];
    logic [15:0] cmd_q [$];
    logic [14:0] rsp_q [$];
    logic [15:0] cur, prev_cmd, rnd;
    logic [7:0]  prev_rdata;
    logic        prev_valid, prev_done, prev_rready;
    bit          outstanding, any_nd;
    int          n;

    vecs[0] = '{rw: 0, addr: 7'h01, wdata: 8'h00, rdata: 8'h00, exp_rsp: 0, exp_rsp_addr: 7'h00, exp_rsp_rdata: 8'h00};
    vecs[1] = '{rw: 1, addr: 7'h7F, wdata: 8'h12, rdata: 8'hFF, exp_rsp: 1, exp_rsp_addr: 7'h7F, exp_rsp_rdata: 8'hFF};
    vecs[2] = '{rw: 0, addr: 7'h00, wdata: 8'hFF, rdata: 8'h99, exp_rsp: 0, exp_rsp_addr: 7'h00, exp_rsp_rdata: 8'h00};
    vecs[3] = '{rw: 1, addr: 7'h00, wdata: 8'hAA, rdata: 8'h00, exp_rsp: 1, exp_rsp_addr: 7'h00, exp_rsp_rdata: 8'h00};
    vecs[4] = '{rw: 1, addr: 7'h55, wdata: 8'h33, rdata: 8'h3C, exp_rsp: 1, exp_rsp_addr: 7'h55, exp_rsp_rdata: 8'h3C};

    clk = 0; reset = 0;
    cmd_valid = 0; cmd_rw_bar = 0; cmd_addr = '0; cmd_wdata = '0;
    Rdata = '0; done_c = 0; rsp_ready = 0;
    #3;
    check_reset_values("por");
    tick();
    tick();
    reset = 1;
    tick();

    // Write to an idle queue: strobe appears two edges after acceptance and lasts one cycle.
    push(0, 7'h2A, 8'h5C);
    check("w_lat_t0_nd", new_data, 0);
    tick();
    check("w_lat_t1_nd", new_data, 0);
    tick();
    check("w_lat_t2_nd", new_data, 1);
    check("w_addr", Addr, 7'h2A);
    check("w_wdata", Wdata, 8'h5C);
    check("w_rw_bar", rw_bar, 0);
    check("w_busy", busy, 1);
    tick();
    check("w_pulse_end", new_data, 0);
    check("w_addr_hold", Addr, 7'h2A);
    complete(8'h00);
    check("w_done_busy", busy, 0);
    check("w_no_rsp", rsp_valid, 0);

    // Read: response visible the cycle after done_c.
    push(1, 7'h50, 8'h00);
    wait_nd("r_issue");
    check("r_rw_bar", rw_bar, 1);
    check("r_addr", Addr, 7'h50);
    complete(8'hA7);
    check("r_rsp_valid", rsp_valid, 1);
    check("r_rsp_addr", rsp_addr, 7'h50);
    check("r_rsp_rdata", rsp_rdata, 8'hA7);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("r_rsp_popped", rsp_valid, 0);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      push(v.rw, v.addr, v.wdata);
      wait_nd("vec_issue");
      check("vec_cmd", {rw_bar, Addr, Wdata}, {v.rw, v.addr, v.wdata});
      complete(v.rdata);
      check("vec_rsp_valid", rsp_valid, v.exp_rsp);
      if (v.exp_rsp) check("vec_rsp_data", {rsp_addr, rsp_rdata}, {v.exp_rsp_addr, v.exp_rsp_rdata});
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end

    // Command FIFO full while the master holds off done_c.
    do_reset();
    push(0, 7'h11, 8'h01);
    wait_nd("full_a_issue");
    push(0, 7'h12, 8'h02);
    push(1, 7'h13, 8'h03);
    push(0, 7'h14, 8'h04);
    push(1, 7'h15, 8'h05);
    check("full_ready_low", cmd_ready, 0);
    cmd_rw_bar = 0; cmd_addr = 7'h16; cmd_wdata = 8'h06; cmd_valid = 1;
    repeat (3) tick();
    check("full_hold", cmd_ready, 0);
    complete(8'h00);
    check("full_d0_ready", cmd_ready, 0);
    tick();
    check("full_issue_ready", cmd_ready, 0);
    check("full_issue_nd", new_data, 0);
    tick();
    check("full_pop_ready", cmd_ready, 1);
    check("full_pop_nd", new_data, 1);
    check("full_pop_addr", Addr, 7'h12);
    tick();
    cmd_valid = 0;
    check("full_fifth_accepted", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      complete(8'h00);
      wait_nd("full_order_issue");
      check("full_order_addr", Addr, 7'(8'h13 + i));
    end
    complete(8'h00);

    // Response FIFO full blocks further issue until one response is consumed.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1, 7'(8'h20 + i), 8'h00);
      wait_nd("rfull_issue");
      complete(8'(8'hB0 + i));
    end
    check("rfull_valid", rsp_valid, 1);
    push(1, 7'h24, 8'h00);
    any_nd = 0;
    repeat (6) begin
      tick();
      any_nd |= new_data;
    end
    check("rfull_blocked", {31'd0, any_nd}, 0);
    check("rfull_head", {rsp_addr, rsp_rdata}, {7'h20, 8'hB0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    wait_nd("rfull_release");
    check("rfull_fifth_addr", Addr, 7'h24);
    complete(8'hB4);
    for (int i = 0; i < 4; i++) exp_rsp[i] = {7'(8'h21 + i), 8'(8'hB1 + i)};
    for (int i = 0; i < 4; i++) begin
      check("rfull_drain", {rsp_addr, rsp_rdata}, exp_rsp[i]);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end
    check("rfull_empty", rsp_valid, 0);

    // Asynchronous reset while waiting on the master.
    do_reset();
    push(1, 7'h33, 8'h44);
    wait_nd("rst_issue");
    #2;
    reset = 0;
    #1;
    check_reset_values("rst_wait");
    done_c = 1; Rdata = 8'hEE;
    tick();
    reset = 1;
    tick();
    tick();
    done_c = 0;
    check("rst_no_rsp", rsp_valid, 0);
    check("rst_idle", busy, 0);

`ifdef I2C_CMD_QUEUE_TIMEOUT_EN
    do_reset();
    push(0, 7'h3C, 8'hC3);
    wait_nd("to_issue");
    n = 0;
    while (busy && n < 1100) begin
      tick();
      n++;
    end
    check("to_cycles", n, 1024);
    check("to_err", err_timeout, 1);
    check("to_no_rsp", rsp_valid, 0);
    push(1, 7'h3D, 8'h00);
    wait_nd("to_next_issue");
    check("to_next_addr", Addr, 7'h3D);
    complete(8'h5A);
    check("to_err_sticky", err_timeout, 1);
    do_reset();
    check("to_err_cleared", err_timeout, 0);
`else
    do_reset();
    push(0, 7'h3C, 8'hC3);
    wait_nd("nto_issue");
    repeat (1100) tick();
    check("nto_still_busy", busy, 1);
    check("nto_err", err_timeout, 0);
    complete(8'h00);
    check("nto_done", busy, 0);
`endif

    // Random traffic against a transaction-level queue model.
    do_reset();
    outstanding = 0;
    cur = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit drain;
      bit cmd_full_pre, rsp_ne_pre, out_pre;
      drain = (cyc >= 300);
      rnd = 16'($urandom);
      cmd_valid  = drain ? 1'b0 : ($urandom_range(0, 99) < 60);
      cmd_rw_bar = rnd[15];
      cmd_addr   = rnd[14:8];
      cmd_wdata  = rnd[7:0];
      done_c     = drain ? 1'b1 : ($urandom_range(0, 3) == 0);
      Rdata      = 8'($urandom);
      rsp_ready  = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
      prev_valid = cmd_valid; prev_cmd = rnd; prev_done = done_c;
      prev_rdata = Rdata; prev_rready = rsp_ready;
      tick();

      cmd_full_pre = (cmd_q.size() == DEPTH);
      rsp_ne_pre   = (rsp_q.size() != 0);
      out_pre      = outstanding;
      if (prev_rready && rsp_ne_pre) void'(rsp_q.pop_front());
      if (prev_done && out_pre) begin
        outstanding = 0;
        if (cur[15]) rsp_q.push_back({cur[14:8], prev_rdata});
      end
      if (new_data) begin
        check("rnd_single_outstanding", {31'd0, outstanding}, 0);
        check("rnd_issue_nonempty", {31'd0, cmd_q.size() != 0}, 1);
        if (cmd_q.size() != 0) begin
          cur = cmd_q.pop_front();
          check("rnd_issue_cmd", {rw_bar, Addr, Wdata}, cur);
          outstanding = 1;
        end
      end
      if (prev_valid && !cmd_full_pre) cmd_q.push_back(prev_cmd);
      check("rnd_cmd_ready", cmd_ready, {31'd0, cmd_q.size() < DEPTH});
      check("rnd_rsp_valid", rsp_valid, {31'd0, rsp_q.size() != 0});
      if (rsp_q.size() != 0) check("rnd_rsp_head", {rsp_addr, rsp_rdata}, rsp_q[0]);
      if (outstanding) check("rnd_busy", busy, 1);
    end
    cmd_valid = 0; done_c = 0; rsp_ready = 0;
    tick();
    check("rnd_end_busy", busy, 0);
    check("rnd_end_rsp", rsp_valid, 0);
    check("rnd_end_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
